// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer controller of a dual-clock FIFO.
// It brings the write-domain gray pointer across into the read clock and decodes it.
// From the decoded pointer it derives empty, occupancy and the RAM read address.
// It returns its own gray read pointer to the write side.
// It also flags underflow attempts and illegal write-pointer behaviour.
module async_fifo_rd_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  input  logic                  rd_en,
  output logic                  rd_ack,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow,
  output logic                  ptr_err
);

  localparam int PW = ADDR_WIDTH + 1;

  typedef logic [PW-1:0] ptr_t;

  // Occupancy limit. A count above this means the write side overran the read side.
  localparam ptr_t DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  function automatic ptr_t b2g(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t g2b(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
  ptr_t wr_bin_q, wr_bin_d;
  ptr_t rd_bin_q, rd_bin_d;
  ptr_t rd_ptr_gray_q, rd_ptr_gray_d;
  logic underflow_q, underflow_d;
  logic ptr_err_q, ptr_err_d;

  ptr_t wq;
  ptr_t gray_diff;
  logic bad_step;
  logic overrun;

  assign wq       = sync_q[SYNC_STAGES-1];
  // Only registered pointers feed occupancy, so empty has no combinational input path.
  assign rd_count = wr_bin_q - rd_bin_q;
  assign empty    = (rd_count == '0);
  // Acceptance is held off while reset is asserted.
  // This keeps a stale non-empty state from issuing a RAM read.
  assign rd_ack   = rd_en & ~empty & ~rst;
  assign rd_addr  = rd_bin_q[ADDR_WIDTH-1:0];

  assign rd_ptr_gray = rd_ptr_gray_q;
  assign underflow   = underflow_q;
  assign ptr_err     = ptr_err_q;

  // Next-state logic: synchroniser shift, pointer decode, read advance and error tracking.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    sync_d        = sync_q;
    wr_bin_d      = g2b(wq);
    rd_bin_d      = rd_bin_q;
    rd_ptr_gray_d = rd_ptr_gray_q;

    sync_d[0] = wr_ptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end

    if (rd_ack) begin
      rd_bin_d      = rd_bin_q + 1'b1;
      rd_ptr_gray_d = b2g(rd_bin_d);
    end

    underflow_d = rd_en & empty;

    // A legal gray step changes at most one bit.
    // x & (x-1) is non-zero exactly when x has two or more bits set.
    gray_diff = wq ^ b2g(wr_bin_q);
    bad_step  = |(gray_diff & (gray_diff - 1'b1));
    overrun   = (rd_count > DEPTH);
    ptr_err_d = ptr_err_q | bad_step | overrun;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the synchroniser chain is reset too.
      // A stale pointer left in it would be decoded after reset as real write progress.
      sync_q        <= '0;
      wr_bin_q      <= '0;
      rd_bin_q      <= '0;
      rd_ptr_gray_q <= '0;
      underflow_q   <= 1'b0;
      ptr_err_q     <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      wr_bin_q      <= wr_bin_d;
      rd_bin_q      <= rd_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      underflow_q   <= underflow_d;
      ptr_err_q     <= ptr_err_d;
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed self-checking bench for async_fifo_rd_ctrl (ADDR_WIDTH=3, SYNC_STAGES=2).
module tb_async_fifo_rd_ctrl;

  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic [AW:0]   wr_ptr_gray;
  logic          rd_en;
  logic          rd_ack;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr_gray;
  logic          empty;
  logic [AW:0]   rd_count;
  logic          underflow;
  logic          ptr_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  async_fifo_rd_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_en       (rd_en),
    .rd_ack      (rd_ack),
    .rd_addr     (rd_addr),
    .rd_ptr_gray (rd_ptr_gray),
    .empty       (empty),
    .rd_count    (rd_count),
    .underflow   (underflow),
    .ptr_err     (ptr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gray code of each 4-bit binary pointer value, written out by hand.
  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_ptr_gray = '0;
    rd_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] prev_rpg;
    logic       saw_wrap;

    rst = 1'b1;
    wr_ptr_gray = '0;
    rd_en = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_empty", empty, 1);
    check("rst_count", rd_count, 0);
    check("rst_rpg", rd_ptr_gray, 0);
    check("rst_err", ptr_err, 0);
    check("rst_uflow", underflow, 0);
    check("rst_ack", rd_ack, 0);
    rst = 1'b0;

    // Fill visibility: wr=1 at edge E, 3 at E+1
    wr_ptr_gray = 4'd1;
    tick();                                   // E
    check("fill_e0_empty", empty, 1);
    wr_ptr_gray = 4'd3;
    tick();                                   // E+1
    check("fill_e1_empty", empty, 1);
    tick();                                   // E+2
    check("fill_e2_empty", empty, 0);
    check("fill_e2_count", rd_count, 1);
    tick();                                   // E+3
    check("fill_e3_count", rd_count, 2);

    // Drain and underflow
    rd_en = 1'b1;
    #1;
    check("drain_ack0", rd_ack, 1);
    check("drain_addr0", rd_addr, 0);
    tick();
    check("drain_rpg0", rd_ptr_gray, 1);
    check("drain_ack1", rd_ack, 1);
    check("drain_addr1", rd_addr, 1);
    tick();
    check("drain_rpg1", rd_ptr_gray, 3);
    check("drain_empty", empty, 1);
    check("drain_uflow_none", underflow, 0);
    check("drain_ack2", rd_ack, 0);
    tick();
    check("uflow_1", underflow, 1);
    tick();
    check("uflow_2", underflow, 1);
    check("uflow_rpg_hold", rd_ptr_gray, 3);
    rd_en = 1'b0;
    tick();
    check("uflow_clear", underflow, 0);
    check("drain_count", rd_count, 0);

    // Wrap: write pointer walks binary 3..15, 0, 1 while reads keep up
    rd_en = 1'b1;
    saw_wrap = 1'b0;
    prev_rpg = rd_ptr_gray;
    for (int n = 3; n <= 17; n++) begin
      wr_ptr_gray = gray_tab[n % 16];
      tick();
      check("wrap_count_le8", (rd_count <= 4'd8), 1);
      check("wrap_err", ptr_err, 0);
      if (prev_rpg == 4'd8 && rd_ptr_gray == 4'd0) saw_wrap = 1'b1;
      prev_rpg = rd_ptr_gray;
    end
    for (int i = 0; i < 20 && !empty; i++) begin
      tick();
      if (prev_rpg == 4'd8 && rd_ptr_gray == 4'd0) saw_wrap = 1'b1;
      prev_rpg = rd_ptr_gray;
    end
    check("wrap_drained", empty, 1);
    check("wrap_seen_8_to_0", saw_wrap, 1);
    check("wrap_final_rpg", rd_ptr_gray, 1);
    check("wrap_final_err", ptr_err, 0);
    rd_en = 1'b0;

    // Error (a): illegal two-bit gray step 0 -> 3
    do_reset();
    wr_ptr_gray = 4'd3;
    tick();                                   // E
    check("step_err_e0", ptr_err, 0);
    tick();                                   // E+1
    check("step_err_e1", ptr_err, 0);
    tick();                                   // E+2
    check("step_err_set", ptr_err, 1);
    wr_ptr_gray = 4'd2; tick();
    wr_ptr_gray = 4'd6; tick();
    wr_ptr_gray = 4'd7; tick();
    tick();
    tick();
    check("step_err_sticky", ptr_err, 1);
    do_reset();
    check("step_err_cleared", ptr_err, 0);

    // Error (b): legal advance to binary 9 with no reads -> overrun
    for (int k = 1; k <= 9; k++) begin
      wr_ptr_gray = gray_tab[k];
      tick();
    end
    tick();
    check("ovr_count8", rd_count, 8);
    check("ovr_err_at8", ptr_err, 0);
    tick();
    check("ovr_count9", rd_count, 9);
    check("ovr_err_pre", ptr_err, 0);
    tick();
    check("ovr_err_set", ptr_err, 1);

    // Reset mid-operation with occupancy 5 and reads requested
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      wr_ptr_gray = gray_tab[k];
      tick();
    end
    tick();
    tick();
    check("mid_count5", rd_count, 5);
    rd_en = 1'b1;
    rst = 1'b1;
    wr_ptr_gray = '0;
    #1;
    check("mid_ack_in_rst", rd_ack, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_empty", empty, 1);
    check("mid_count", rd_count, 0);
    check("mid_rpg", rd_ptr_gray, 0);
    check("mid_addr", rd_addr, 0);
    check("mid_uflow", underflow, 0);
    check("mid_err", ptr_err, 0);
    check("mid_ack", rd_ack, 0);
    rd_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
